// File: rtl/clock_set_controller.sv
// clock_set_controller
//   Time-setting sequencer for the digital clock. MODE walks through
//   RUN -> SET_HOUR -> SET_MIN -> RUN. Leaving SET_MIN commits the edit with a
//   one-cycle load strobe. INC/DEC edit the active field with wrap-around.
//   An idle set state times out back to RUN without loading.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   mode/inc/dec_pressed_*   debounced button pulses and held levels
//   cur_hours/cur_minutes    live time, captured when editing starts
//   set_hours/set_minutes    edit registers
//   load                     one-cycle commit strobe
//   set_active, edit_field   editing indication (01 hours, 10 minutes)
//   blink                    display-on phase for the edited field
//
// Build option
//   CLOCK_SET_AUTOREPEAT_EN  hold-to-repeat stepping on INC/DEC
module clock_set_controller #(
  parameter int unsigned HOLD_CYCLES    = 50_000_000,
  parameter int unsigned REPEAT_CYCLES  = 10_000_000,
  parameter int unsigned TIMEOUT_CYCLES = 500_000_000,
  parameter int unsigned BLINK_CYCLES   = 25_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       mode_pressed_pulse,
  input  logic       inc_pressed_pulse,
  input  logic       inc_pressed_status,
  input  logic       dec_pressed_pulse,
  input  logic       dec_pressed_status,
  input  logic [4:0] cur_hours,
  input  logic [5:0] cur_minutes,
  output logic [4:0] set_hours,
  output logic [5:0] set_minutes,
  output logic       load,
  output logic       set_active,
  output logic [1:0] edit_field,
  output logic       blink
);

  typedef enum logic [1:0] {ST_RUN = 2'd0, ST_SET_HOUR = 2'd1, ST_SET_MIN = 2'd2} state_e;

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam int BW = $clog2(BLINK_CYCLES);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BL_LAST = BW'(BLINK_CYCLES - 1);

  state_e        state_q, state_d;
  logic [4:0]    set_hours_q, set_hours_d;
  logic [5:0]    set_minutes_q, set_minutes_d;
  logic          load_q, load_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          blink_q, blink_d;

  logic in_set, activity, timeout;
  logic inc_step, dec_step, do_inc, do_dec;
  logic rpt_inc, rpt_dec;

  assign in_set   = (state_q != ST_RUN);
  assign activity = mode_pressed_pulse | inc_pressed_pulse | dec_pressed_pulse |
                    inc_pressed_status | dec_pressed_status;
  // Any button activity this cycle also resets the idle count, so it never aborts.
  assign timeout  = in_set && (to_cnt_q == TO_LAST) && !activity;

  // MODE wins over a same-cycle step; opposing steps cancel.
  assign inc_step = in_set & ~mode_pressed_pulse & (inc_pressed_pulse | rpt_inc);
  assign dec_step = in_set & ~mode_pressed_pulse & (dec_pressed_pulse | rpt_dec);
  assign do_inc   = inc_step & ~dec_step;
  assign do_dec   = dec_step & ~inc_step;

`ifdef CLOCK_SET_AUTOREPEAT_EN
  localparam int HW = $clog2((HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);

  logic          hold_act_q, hold_act_d;
  logic          hold_rep_q, hold_rep_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          one_held;

  assign one_held = inc_pressed_status ^ dec_pressed_status;

  // Armed by the press pulse; first step after HOLD_CYCLES, then every REPEAT_CYCLES.
  always_comb begin
    hold_act_d = hold_act_q;
    hold_rep_d = hold_rep_q;
    hold_cnt_d = hold_cnt_q;
    rpt_inc    = 1'b0;
    rpt_dec    = 1'b0;
    if (!in_set || mode_pressed_pulse || !one_held) begin
      hold_act_d = 1'b0;
      hold_rep_d = 1'b0;
      hold_cnt_d = '0;
    end else if (inc_pressed_pulse || dec_pressed_pulse) begin
      hold_act_d = 1'b1;
      hold_rep_d = 1'b0;
      hold_cnt_d = '0;
    end else if (hold_act_q) begin
      if (hold_cnt_q == (hold_rep_q ? REP_LAST : HOLD_LAST)) begin
        rpt_inc    = inc_pressed_status;
        rpt_dec    = dec_pressed_status;
        hold_rep_d = 1'b1;
        hold_cnt_d = '0;
      end else begin
        hold_cnt_d = hold_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_act_q <= 1'b0;
      hold_rep_q <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      hold_act_q <= hold_act_d;
      hold_rep_q <= hold_rep_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end
`else
  logic unused_hold_params;
  assign unused_hold_params = (HOLD_CYCLES >= 2) ^ (REPEAT_CYCLES >= 2);
  assign rpt_inc = 1'b0;
  assign rpt_dec = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    set_hours_d   = set_hours_q;
    set_minutes_d = set_minutes_q;
    load_d        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_pressed_pulse) begin
          state_d       = ST_SET_HOUR;
          set_hours_d   = cur_hours;
          set_minutes_d = cur_minutes;
        end
      end
      ST_SET_HOUR: begin
        if (mode_pressed_pulse) state_d = ST_SET_MIN;
        else if (timeout)       state_d = ST_RUN;
        if (do_inc) set_hours_d = (set_hours_q == 5'd23) ? 5'd0 : set_hours_q + 5'd1;
        if (do_dec) set_hours_d = (set_hours_q == 5'd0) ? 5'd23 : set_hours_q - 5'd1;
      end
      ST_SET_MIN: begin
        if (mode_pressed_pulse) begin
          state_d = ST_RUN;
          load_d  = 1'b1;
        end else if (timeout) begin
          state_d = ST_RUN;
        end
        if (do_inc) set_minutes_d = (set_minutes_q == 6'd59) ? 6'd0 : set_minutes_q + 6'd1;
        if (do_dec) set_minutes_d = (set_minutes_q == 6'd0) ? 6'd59 : set_minutes_q - 6'd1;
      end
      default: state_d = ST_RUN;
    endcase

    if (!in_set || activity || (state_d != state_q)) to_cnt_d = '0;
    else                                             to_cnt_d = to_cnt_q + 1'b1;

    // Restart the blink phase "on" whenever the user does something visible.
    if (state_d == ST_RUN) begin
      blink_d     = 1'b0;
      blink_cnt_d = '0;
    end else if ((state_d != state_q) || do_inc || do_dec) begin
      blink_d     = 1'b1;
      blink_cnt_d = '0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_d     = ~blink_q;
      blink_cnt_d = '0;
    end else begin
      blink_d     = blink_q;
      blink_cnt_d = blink_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_RUN;
      set_hours_q   <= '0;
      set_minutes_q <= '0;
      load_q        <= 1'b0;
      to_cnt_q      <= '0;
      blink_cnt_q   <= '0;
      blink_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      set_hours_q   <= set_hours_d;
      set_minutes_q <= set_minutes_d;
      load_q        <= load_d;
      to_cnt_q      <= to_cnt_d;
      blink_cnt_q   <= blink_cnt_d;
      blink_q       <= blink_d;
    end
  end

  assign set_hours   = set_hours_q;
  assign set_minutes = set_minutes_q;
  assign load        = load_q;
  assign set_active  = in_set;
  assign edit_field  = (state_q == ST_SET_HOUR) ? 2'b01 :
                       (state_q == ST_SET_MIN)  ? 2'b10 : 2'b00;
  assign blink       = blink_q;

endmodule

// File: tb/tb_clock_set_controller.sv
// Directed bench for clock_set_controller with small timing parameters.
module tb_clock_set_controller;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       mode_p = 1'b0, inc_p = 1'b0, inc_s = 1'b0, dec_p = 1'b0, dec_s = 1'b0;
  logic [4:0] cur_h = '0;
  logic [5:0] cur_m = '0;
  logic [4:0] set_h;
  logic [5:0] set_m;
  logic       load, set_active, blink;
  logic [1:0] edit_field;

  int checks = 0;
  int errors = 0;

  clock_set_controller #(
    .HOLD_CYCLES(8), .REPEAT_CYCLES(4), .TIMEOUT_CYCLES(64), .BLINK_CYCLES(16)
  ) dut (
    .clk(clk), .rst(rst),
    .mode_pressed_pulse(mode_p),
    .inc_pressed_pulse(inc_p), .inc_pressed_status(inc_s),
    .dec_pressed_pulse(dec_p), .dec_pressed_status(dec_s),
    .cur_hours(cur_h), .cur_minutes(cur_m),
    .set_hours(set_h), .set_minutes(set_m),
    .load(load), .set_active(set_active), .edit_field(edit_field), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One-edge pulses; status follows the pulse as a debounced button would.
  task automatic press_mode();
    mode_p = 1'b1; tick(); mode_p = 1'b0;
  endtask
  task automatic press_inc();
    inc_p = 1'b1; inc_s = 1'b1; tick(); inc_p = 1'b0; inc_s = 1'b0;
  endtask
  task automatic press_dec();
    dec_p = 1'b1; dec_s = 1'b1; tick(); dec_p = 1'b0; dec_s = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (set_h !== 5'd0) begin errors++; $display("FAIL reset_hours got=%0d exp=0", set_h); end
    checks++; if (set_m !== 6'd0) begin errors++; $display("FAIL reset_minutes got=%0d exp=0", set_m); end
    checks++; if ({load, set_active, blink, edit_field} !== 5'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=00000", {load, set_active, blink, edit_field});
    end
  endtask

  task automatic test_capture_commit();
    cur_h = 5'd13; cur_m = 6'd45;
    press_mode();
    checks++; if (edit_field !== 2'b01 || set_active !== 1'b1 || blink !== 1'b1) begin
      errors++; $display("FAIL capture_state got=%b/%b/%b exp=01/1/1", edit_field, set_active, blink);
    end
    checks++; if (set_h !== 5'd13 || set_m !== 6'd45) begin
      errors++; $display("FAIL capture_time got=%0d:%0d exp=13:45", set_h, set_m);
    end
    press_inc();
    checks++; if (set_h !== 5'd14) begin errors++; $display("FAIL inc_hours got=%0d exp=14", set_h); end
    press_mode();
    checks++; if (edit_field !== 2'b10) begin errors++; $display("FAIL to_min got=%b exp=10", edit_field); end
    press_dec(); press_dec();
    checks++; if (set_m !== 6'd43) begin errors++; $display("FAIL dec_minutes got=%0d exp=43", set_m); end
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_early got=%b exp=0", load); end
    press_mode();
    checks++; if (load !== 1'b1) begin errors++; $display("FAIL load_strobe got=%b exp=1", load); end
    checks++; if (set_h !== 5'd14 || set_m !== 6'd43 || set_active !== 1'b0 || edit_field !== 2'b00) begin
      errors++; $display("FAIL commit_out got=%0d:%0d act=%b fld=%b exp=14:43 act=0 fld=00",
                         set_h, set_m, set_active, edit_field);
    end
    tick();
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL load_one_cycle got=%b exp=0", load); end
  endtask

  task automatic test_wrap();
    cur_h = 5'd23; cur_m = 6'd59;
    press_mode();
    press_inc();
    checks++; if (set_h !== 5'd0) begin errors++; $display("FAIL wrap_h_inc got=%0d exp=0", set_h); end
    press_dec();
    checks++; if (set_h !== 5'd23) begin errors++; $display("FAIL wrap_h_dec got=%0d exp=23", set_h); end
    press_mode();
    press_inc();
    checks++; if (set_m !== 6'd0) begin errors++; $display("FAIL wrap_m_inc got=%0d exp=0", set_m); end
    checks++; if (set_h !== 5'd23) begin errors++; $display("FAIL no_carry got=%0d exp=23", set_h); end
    press_dec();
    checks++; if (set_m !== 6'd59) begin errors++; $display("FAIL wrap_m_dec got=%0d exp=59", set_m); end
    press_mode(); tick();
  endtask

  task automatic test_simultaneous();
    cur_h = 5'd5; cur_m = 6'd30;
    press_mode();
    inc_p = 1'b1; dec_p = 1'b1; tick(); inc_p = 1'b0; dec_p = 1'b0;
    checks++; if (set_h !== 5'd5) begin errors++; $display("FAIL incdec_cancel got=%0d exp=5", set_h); end
    mode_p = 1'b1; inc_p = 1'b1; tick(); mode_p = 1'b0; inc_p = 1'b0;
    checks++; if (edit_field !== 2'b10 || set_h !== 5'd5) begin
      errors++; $display("FAIL mode_beats_inc got fld=%b h=%0d exp fld=10 h=5", edit_field, set_h);
    end
    press_mode(); tick();
  endtask

  task automatic test_run_ignores();
    press_inc(); press_dec(); press_dec();
    checks++; if (set_h !== 5'd5 || set_m !== 6'd30 || edit_field !== 2'b00) begin
      errors++; $display("FAIL run_ignore got=%0d:%0d fld=%b exp=5:30 fld=00", set_h, set_m, edit_field);
    end
  endtask

  task automatic test_timeout();
    int loads = 0;
    cur_h = 5'd7; cur_m = 6'd20;
    press_mode();
    for (int i = 0; i < 63; i++) begin tick(); if (load) loads++; end
    checks++; if (edit_field !== 2'b01) begin errors++; $display("FAIL timeout_early got=%b exp=01", edit_field); end
    tick(); if (load) loads++;
    checks++; if (edit_field !== 2'b00 || set_active !== 1'b0 || blink !== 1'b0) begin
      errors++; $display("FAIL timeout_abort got fld=%b act=%b blk=%b exp 00/0/0", edit_field, set_active, blink);
    end
    tick(); if (load) loads++;
    checks++; if (loads !== 0 || set_h !== 5'd7) begin
      errors++; $display("FAIL timeout_noload got loads=%0d h=%0d exp 0/7", loads, set_h);
    end
  endtask

  task automatic test_blink();
    cur_h = 5'd1; cur_m = 6'd2;
    press_mode();
    repeat (15) tick();
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_hold got=%b exp=1", blink); end
    tick();
    checks++; if (blink !== 1'b0) begin errors++; $display("FAIL blink_toggle got=%b exp=0", blink); end
    press_inc();
    checks++; if (blink !== 1'b1) begin errors++; $display("FAIL blink_step got=%b exp=1", blink); end
    press_mode(); press_mode();
    checks++; if (blink !== 1'b0 || load !== 1'b1) begin
      errors++; $display("FAIL blink_run got blk=%b load=%b exp 0/1", blink, load);
    end
    tick();
  endtask

  task automatic test_autorepeat();
    logic [5:0] exp_m;
`ifdef CLOCK_SET_AUTOREPEAT_EN
    exp_m = 6'd14;
`else
    exp_m = 6'd11;
`endif
    cur_h = 5'd0; cur_m = 6'd10;
    press_mode(); press_mode();
    inc_p = 1'b1; inc_s = 1'b1; tick(); inc_p = 1'b0;
    repeat (19) tick();
    inc_s = 1'b0; tick(); tick();
    checks++; if (set_m !== exp_m) begin errors++; $display("FAIL autorepeat got=%0d exp=%0d", set_m, exp_m); end
  endtask

  task automatic test_reset_mid_edit();
    checks++; if (edit_field !== 2'b10) begin errors++; $display("FAIL pre_reset_state got=%b exp=10", edit_field); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (set_h !== 5'd0 || set_m !== 6'd0 || {load, set_active, blink, edit_field} !== 5'b0) begin
      errors++; $display("FAIL reset_mid_edit got=%0d:%0d flags=%b exp 0:0 00000",
                         set_h, set_m, {load, set_active, blink, edit_field});
    end
    tick();
    checks++; if (load !== 1'b0) begin errors++; $display("FAIL reset_noload got=%b exp=0", load); end
  endtask

  initial begin
    test_reset();
    test_capture_commit();
    test_wrap();
    test_simultaneous();
    test_run_ignores();
    test_timeout();
    test_blink();
    test_autorepeat();
    test_reset_mid_edit();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
